// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

  localparam int ADDR_W          = 16;
  localparam int WORD_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int OFFSET_W        = 3;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  // Saturating 16-bit increment used by the optional performance counters.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction data store: SETS x 8 words x 16 bits, one synchronous write
// port for line fills and one combinational read port for same-cycle hits.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int SETS = 64,
  localparam int IW  = $clog2(SETS)
) (
  input  logic                clk,
  input  logic                i_wen,
  input  logic [IW-1:0]       i_windex,
  input  logic [OFFSET_W-1:0] i_woffset,
  input  logic [WORD_W-1:0]   i_wdata,
  input  logic [IW-1:0]       i_rindex,
  input  logic [OFFSET_W-1:0] i_roffset,
  output logic [WORD_W-1:0]   o_rdata
);

  logic [WORD_W-1:0] r_mem [SETS*WORDS_PER_BLOCK];

  always_ff @(posedge clk) begin
    if (i_wen) begin
      r_mem[{i_windex, i_woffset}] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[{i_rindex, i_roffset}];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped I-cache with 8-word block fill FSM (IDLE/REQ/WAIT).
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int SETS    = 64,
  parameter int MEM_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic [WORD_W-1:0]  instr,
  output logic               instr_valid,
  output logic               miss_stall,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [WORD_W-1:0]  mem_data,
  input  logic               mem_data_valid
`ifdef ICACHE_PERF_EN
  ,
  output logic [15:0]        hit_cnt,
  output logic [15:0]        miss_cnt
`endif
);

  localparam int IW    = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 4 - IW;

  // MEM_LAT only shapes timing outside this block; reject nonsense values early.
  generate
    if (SETS < 2 || SETS > 256 || (SETS & (SETS - 1)) != 0 || MEM_LAT < 1) begin : g_bad_param
      $error("icache_ctrl: illegal SETS or MEM_LAT");
    end
  endgenerate

  state_t              r_state;
  state_t              w_state_next;
  logic [TAG_W-1:0]    r_fill_tag;
  logic [IW-1:0]       r_fill_index;
  logic [2:0]          r_req_cnt;
  logic [2:0]          r_ret_cnt;
  logic [SETS-1:0]     r_valid;
  logic [TAG_W-1:0]    r_tag [SETS];

  logic [OFFSET_W-1:0] w_offset;
  logic [IW-1:0]       w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_lookup;
  logic                w_hit;
  logic                w_miss;
  logic                w_ret;
  logic                w_last_ret;
  logic [WORD_W-1:0]   w_rdata;
  logic                w_unused_pc0;

  assign w_offset     = pc_addr[3:1];
  assign w_index      = pc_addr[3+IW:4];
  assign w_tag        = pc_addr[ADDR_W-1:4+IW];
  assign w_unused_pc0 = pc_addr[0];

  assign w_lookup   = fetch_en && (r_state == IDLE);
  assign w_hit      = w_lookup && r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_miss     = w_lookup && !w_hit;
  // Returns seen in IDLE are stale (e.g. issued before a reset) and dropped.
  assign w_ret      = mem_data_valid && (r_state != IDLE);
  assign w_last_ret = w_ret && (r_ret_cnt == 3'd7);

  icache_data_array #(.SETS(SETS)) u_data (
    .clk       (clk),
    .i_wen     (w_ret),
    .i_windex  (r_fill_index),
    .i_woffset (r_ret_cnt),
    .i_wdata   (mem_data),
    .i_rindex  (w_index),
    .i_roffset (w_offset),
    .o_rdata   (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_req      = 1'b0;
    mem_addr     = '0;
    case (r_state)
      IDLE: begin
        if (w_miss) w_state_next = REQ;
      end
      REQ: begin
        mem_req  = 1'b1;
        mem_addr = {r_fill_tag, r_fill_index, r_req_cnt, 1'b0};
        if (r_req_cnt == 3'd7) w_state_next = WAIT;
      end
      WAIT: begin
        if (w_last_ret) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign instr_valid = w_hit;
  assign instr       = w_hit ? w_rdata : '0;
  assign miss_stall  = (r_state != IDLE) || w_miss;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_req_cnt <= '0;
      r_ret_cnt <= '0;
      r_valid   <= '0;
    end else begin
      if (r_state == REQ) r_req_cnt <= r_req_cnt + 3'd1;
      if (w_ret)          r_ret_cnt <= r_ret_cnt + 3'd1;
      if (w_last_ret)     r_valid[r_fill_index] <= 1'b1;
    end
  end

  // Fill address and tag storage are not reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_fill_tag   <= w_tag;
      r_fill_index <= w_index;
    end
    if (w_last_ret) begin
      r_tag[r_fill_index] <= r_fill_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_hit)  r_hit_cnt  <= sat_inc(r_hit_cnt);
      if (w_miss) r_miss_cnt <= sat_inc(r_miss_cnt);
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a fixed-latency in-order memory model.
module tb_icache_ctrl;

  localparam int MEM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [15:0] pc_addr;
  logic [15:0] instr;
  logic        instr_valid;
  logic        miss_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_data_valid;
`ifdef ICACHE_PERF_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  icache_ctrl #(.SETS(64), .MEM_LAT(MEM_LAT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .pc_addr        (pc_addr),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .miss_stall     (miss_stall),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_data_valid (mem_data_valid)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt        (hit_cnt),
    .miss_cnt       (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory contents: word at byte address a is (a*7) ^ 16'h3C5A.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd7) ^ 16'h3C5A;
  endfunction

  // A request seen in cycle c is returned during cycle c+MEM_LAT.
  logic        sh_v [MEM_LAT];
  logic [15:0] sh_a [MEM_LAT];

  always @(negedge clk) begin
    mem_data_valid = sh_v[MEM_LAT-1];
    mem_data       = sh_v[MEM_LAT-1] ? mem_word(sh_a[MEM_LAT-1]) : 16'h0000;
    for (int i = MEM_LAT - 1; i > 0; i--) begin
      sh_v[i] = sh_v[i-1];
      sh_a[i] = sh_a[i-1];
    end
    sh_v[0] = mem_req;
    sh_a[0] = mem_addr;
  end

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One hit cycle at pc a.
  task automatic hit(input logic [15:0] a);
    @(negedge clk);
    fetch_en = 1'b1;
    pc_addr  = a;
    #1;
    $display("hit  pc=%h instr=%h valid=%0b stall=%0b", a, instr, instr_valid, miss_stall);
    check_value("hit_valid", {15'd0, instr_valid}, 16'd1);
    check_value("hit_instr", instr, mem_word(a));
    check_value("hit_stall", {15'd0, miss_stall}, 16'd0);
    check_value("hit_memreq", {15'd0, mem_req}, 16'd0);
  endtask

  // Miss at pc a (cycle 0) through cycle 12; optional pc move to alt at cycle 5.
  task automatic miss_fill(input logic [15:0] a, input logic sw, input logic [15:0] alt);
    logic [15:0] base;
    base = {a[15:4], 4'h0};
    @(negedge clk);
    fetch_en = 1'b1;
    pc_addr  = a;
    #1;
    $display("miss pc=%h stall=%0b valid=%0b", a, miss_stall, instr_valid);
    check_value("miss_stall0", {15'd0, miss_stall}, 16'd1);
    check_value("miss_valid0", {15'd0, instr_valid}, 16'd0);
    check_value("miss_instr0", instr, 16'h0000);
    check_value("miss_memreq0", {15'd0, mem_req}, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (sw && k == 5) pc_addr = alt;
      #1;
      check_value("fill_stall", {15'd0, miss_stall}, 16'd1);
      check_value("fill_valid", {15'd0, instr_valid}, 16'd0);
      if (k <= 8) begin
        check_value("fill_req", {15'd0, mem_req}, 16'd1);
        check_value("fill_addr", mem_addr, base + 16'(2 * (k - 1)));
      end else begin
        check_value("wait_req", {15'd0, mem_req}, 16'd0);
        check_value("wait_addr", mem_addr, 16'h0000);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_LAT; i++) begin
      sh_v[i] = 1'b0;
      sh_a[i] = 16'h0000;
    end
    mem_data_valid = 1'b0;
    mem_data       = 16'h0000;
    rst_n    = 1'b0;
    fetch_en = 1'b0;
    pc_addr  = 16'h0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_value("rst_valid", {15'd0, instr_valid}, 16'd0);
    check_value("rst_instr", instr, 16'h0000);
    check_value("rst_stall", {15'd0, miss_stall}, 16'd0);
    check_value("rst_memreq", {15'd0, mem_req}, 16'd0);
    check_value("rst_memaddr", mem_addr, 16'h0000);
`ifdef ICACHE_PERF_EN
    check_value("rst_hitcnt", hit_cnt, 16'h0000);
    check_value("rst_misscnt", miss_cnt, 16'h0000);
`endif

    // Cold miss on 0x0000, then sequential hits across the block.
    miss_fill(16'h0000, 1'b0, 16'h0000);
    hit(16'h0000);
    check_value("cold_word0", instr, 16'h3C5A);
    for (int w = 1; w <= 6; w++) hit(16'(2 * w));
`ifdef ICACHE_PERF_EN
    @(posedge clk);
    #1;
    check_value("perf_hitcnt7", hit_cnt, 16'd7);
    check_value("perf_misscnt1", miss_cnt, 16'd1);
`endif
    hit(16'h000E);

    // Conflict: 0x0400 shares index 0 with a different tag.
    miss_fill(16'h0400, 1'b0, 16'h0000);
    hit(16'h0400);
    hit(16'h040E);

    // Re-fetch of 0x0000 misses; pc moves to 0x0010 mid-fill.
    miss_fill(16'h0000, 1'b1, 16'h0010);
    miss_fill(16'h0010, 1'b0, 16'h0000);
    hit(16'h0010);
    hit(16'h001E);
    hit(16'h0006);

    // Reset while in WAIT: stale returns must not disturb the next fill.
    @(negedge clk);
    fetch_en = 1'b1;
    pc_addr  = 16'h0020;
    #1;
    check_value("rstfill_stall", {15'd0, miss_stall}, 16'd1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    fetch_en = 1'b0;
    #1;
    $display("reset in WAIT: memreq=%0b stall=%0b", mem_req, miss_stall);
    check_value("midrst_memreq", {15'd0, mem_req}, 16'd0);
    check_value("midrst_stall", {15'd0, miss_stall}, 16'd0);
    check_value("midrst_valid", {15'd0, instr_valid}, 16'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check_value("stale_memreq", {15'd0, mem_req}, 16'd0);
      check_value("stale_stall", {15'd0, miss_stall}, 16'd0);
    end
    miss_fill(16'h0000, 1'b0, 16'h0000);
    hit(16'h0000);
    hit(16'h000A);
    miss_fill(16'h0010, 1'b0, 16'h0000);
    hit(16'h0012);

`ifdef ICACHE_PERF_EN
    // Hold a hitting pc long enough to saturate the hit counter.
    @(negedge clk);
    fetch_en = 1'b1;
    pc_addr  = 16'h0000;
    repeat (65540) @(negedge clk);
    #1;
    check_value("perf_hitsat", hit_cnt, 16'hFFFF);
    @(negedge clk);
    #1;
    check_value("perf_hitsat_hold", hit_cnt, 16'hFFFF);
`endif

    fetch_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
